pipe_ctrl: RTL

Pipeline stall/flush sequencer for the five-stage integer core. It sits beside the pipeline registers (pc, if_id, id_ex, ex_mem, mem_wb) and drives their per-stage hold and flush controls. It arbitrates three sources: load-use stall requests from decode, multi-cycle execute operations, and exception/redirect flushes. Multi-cycle execute ops are sequenced by an internal down-counter and FSM, so execute units only announce the op and its length.

---
 rtl/pipe_ctrl_if.sv | 40 ++++
 rtl/pipe_ctrl.sv | 112 +++++++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: request/control bundle between the pipeline and pipe_ctrl.
// slave = pipe_ctrl side; master = pipeline (requesters and stage registers).
interface pipe_ctrl_if #(
  parameter int STALL_W = 6,
  parameter int CNT_W   = 6
);
  logic               stallreq_id;
  logic               ex_mc_start;
  logic [CNT_W-1:0]   ex_mc_len;
  logic               flush_req;
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic               ex_mc_done;
  logic               busy;
  logic [31:0]        stall_cycles;

  modport slave (
    input  stallreq_id,
    input  ex_mc_start,
    input  ex_mc_len,
    input  flush_req,
    output stall,
    output flush,
    output ex_mc_done,
    output busy,
    output stall_cycles
  );

  modport master (
    output stallreq_id,
    output ex_mc_start,
    output ex_mc_len,
    output flush_req,
    input  stall,
    input  flush,
    input  ex_mc_done,
    input  busy,
    input  stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush sequencer for the five-stage core.
// Ports: clk, rst (async, active-low), bus (pipe_ctrl_if.slave):
//   in:  stallreq_id, ex_mc_start, ex_mc_len, flush_req
//   out: stall[pc,if,id,ex,mem,wb], flush, ex_mc_done, busy, stall_cycles
// Option: PIPE_CTRL_PERF_EN enables the saturating stall_cycles counter.
module pipe_ctrl #(
  parameter int STALL_W = 6,
  parameter int CNT_W   = 6
) (
  input logic          clk,
  input logic          rst,
  pipe_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MC    = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [STALL_W-1:0] ST_MC =
    STALL_W'(6'b001111);
  localparam logic [STALL_W-1:0] ST_LU =
    STALL_W'(6'b000111);

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [STALL_W-1:0] stall_d;
  logic               flush_d;
  logic               done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_d = '0;
    flush_d = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (bus.flush_req) begin
          flush_d = 1'b1;
          state_d = FLUSH;
        end else if (bus.ex_mc_start) begin
          // Length 0/1 completes in the announcing cycle.
          if (bus.ex_mc_len >= CNT_W'(2)) begin
            stall_d = ST_MC;
            cnt_d   = bus.ex_mc_len - CNT_W'(2);
            state_d = MC;
          end else begin
            done_d = 1'b1;
          end
        end else if (bus.stallreq_id) begin
          stall_d = ST_LU;
        end
      end
      MC: begin
        if (bus.flush_req) begin
          flush_d = 1'b1;
          state_d = FLUSH;
        end else if (cnt_q != '0) begin
          stall_d = ST_MC;
          cnt_d   = cnt_q - CNT_W'(1);
        end else begin
          done_d  = 1'b1;
          state_d = RUN;
        end
      end
      FLUSH: begin
        // Second flush cycle; requests ignored.
        flush_d = 1'b1;
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  assign bus.stall      = stall_d;
  assign bus.flush      = flush_d;
  assign bus.ex_mc_done = done_d;
  assign bus.busy       = (state_q != RUN);

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_q <= '0;
    end else if ((stall_d != '0) && (perf_q != '1)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign bus.stall_cycles = perf_q;
`else
  assign bus.stall_cycles = 32'h0;
`endif

endmodule
